// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage of the SIMPLE datapath.
// Holds the 8x16 register file and a per-register pending scoreboard,
// decodes instruction words into AR/BR/IR/store-data and stalls issue on
// RAW/WAW hazards against results not yet written back.
// Optional feature: define OPERAND_BYPASS_EN to forward writeback data
// into the operand read and release hazards in the writeback cycle.
module operand_fetch #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_ir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ar,
   output logic [WIDTH-1:0] br,
   output logic [WIDTH-1:0] ir_out,
   output logic [WIDTH-1:0] st_data,
   input  logic             wb_en,
   input  logic [2:0]       wb_addr,
   input  logic [WIDTH-1:0] wb_data
);

   localparam logic [3:0] OP_CMP = 4'b0101;

   logic [WIDTH-1:0] rf [8];
   logic [7:0]       pend;
   logic [7:0]       pend_next;
   logic [7:0]       busy;
   logic [7:0]       src_mask;
   logic [7:0]       dst_mask;
   logic [1:0]       cls;
   logic [2:0]       ra;
   logic [2:0]       rb;
   logic [3:0]       op;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [WIDTH-1:0] nxt_ar;
   logic [WIDTH-1:0] nxt_br;
   logic [WIDTH-1:0] nxt_st;
   logic             hazard;
   logic             accept;

   assign cls = in_ir[15:14];
   assign ra  = in_ir[13:11];
   assign rb  = in_ir[10:8];
   assign op  = in_ir[7:4];
   assign imm = {{(WIDTH-8){in_ir[7]}}, in_ir[7:0]};

   // Register reads and the effective busy set, with optional writeback forwarding
   always_comb begin
`ifdef OPERAND_BYPASS_EN
      rd_a = (wb_en && (wb_addr == ra) && pend[ra]) ? wb_data : rf[ra];
      rd_b = (wb_en && (wb_addr == rb) && pend[rb]) ? wb_data : rf[rb];
      busy = pend;
      if (wb_en) begin
         busy[wb_addr] = 1'b0;
      end
`else
      rd_a = rf[ra];
      rd_b = rf[rb];
      busy = pend;
`endif
   end

   // Decode class into source/destination masks and the next operand values
   always_comb begin
      src_mask = '0;
      dst_mask = '0;
      nxt_ar   = '0;
      nxt_br   = imm;
      nxt_st   = '0;
      unique case (cls)
         2'b11: begin
            src_mask = (8'b1 << ra) | (8'b1 << rb);
            if (op != OP_CMP) begin
               dst_mask = 8'b1 << rb;
            end
            nxt_ar = rd_a;
            nxt_br = rd_b;
         end
         2'b00: begin
            src_mask = 8'b1 << rb;
            dst_mask = 8'b1 << ra;
            nxt_ar   = rd_b;
         end
         2'b01: begin
            src_mask = (8'b1 << ra) | (8'b1 << rb);
            nxt_ar   = rd_b;
            nxt_st   = rd_a;
         end
         default: begin
            if (ra == 3'b000) begin
               dst_mask = 8'b1 << rb;
            end
         end
      endcase
   end

   assign hazard   = (|(src_mask & busy)) | (|(dst_mask & busy));
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // Scoreboard update: writeback clears first, so a same-cycle issue set wins
   always_comb begin
      pend_next = pend;
      if (wb_en) begin
         pend_next[wb_addr] = 1'b0;
      end
      if (accept) begin
         pend_next = pend_next | dst_mask;
      end
   end

   // Scoreboard and issue registers; reset drops any unconsumed instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= '0;
         out_valid <= 1'b0;
         ar        <= '0;
         br        <= '0;
         ir_out    <= '0;
         st_data   <= '0;
      end else begin
         pend <= pend_next;
         if (accept) begin
            out_valid <= 1'b1;
            ar        <= nxt_ar;
            br        <= nxt_br;
            ir_out    <= in_ir;
            st_data   <= nxt_st;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Register file write port driven by the writeback stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_en) begin
         rf[wb_addr] <= wb_data;
      end
   end

endmodule
